// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared definitions for the ALU command path: the parser, the ALU itself
//   and the result transmitter all draw on these so that opcodes and
//   character codes have a single definition.
//   Contents:
//     OP_*      4-bit ALU opcodes (add, subtract, multiply, quotient, remainder)
//     CH_*      ASCII codes of the characters the parser recognises
//     state_t   parser FSM state encoding
//     decode_op maps an operator character to {is_operator, opcode}
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0100;
    localparam logic [3:0] OP_MOD = 4'b1000;

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_PCT   = 8'h25;
    localparam logic [7:0] CH_STAR  = 8'h2A;
    localparam logic [7:0] CH_PLUS  = 8'h2B;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_SLASH = 8'h2F;
    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;
    localparam logic [7:0] CH_CR    = 8'h0D;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_NUM1  = 2'd1,
        ST_NUM2  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Upper bit flags a recognised operator, lower four bits carry its opcode.
    function automatic logic [4:0] decode_op(input logic [7:0] ch);
        logic [4:0] result;
        result = 5'b0_0000;
        case (ch)
            CH_PLUS:  result = {1'b1, OP_ADD};
            CH_MINUS: result = {1'b1, OP_SUB};
            CH_STAR:  result = {1'b1, OP_MUL};
            CH_SLASH: result = {1'b1, OP_DIV};
            CH_PCT:   result = {1'b1, OP_MOD};
            default:  result = 5'b0_0000;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/dec_acc.sv
// dec_acc
//   Combinational decimal digit accumulator used by the command parser.
//   Given the current accumulator and digit count it validates the incoming
//   byte as an ASCII digit and produces acc*10+digit plus the incremented
//   count, flagging when the new value exceeds 255 or too many digits have
//   been seen.
//   Ports:
//     digit_byte  in   received byte
//     acc_in      in   current 10-bit accumulator
//     cnt_in      in   digits accumulated so far
//     is_digit    out  byte is '0'..'9'
//     acc_out     out  acc_in*10 + digit (low 10 bits)
//     cnt_out     out  cnt_in + 1
//     overflow    out  digit would push value above 255 or count above MAX_DIGITS
module dec_acc
    import alu_pkg::*;
#(
    parameter int MAX_DIGITS = 3,
    parameter int CW         = 3
) (
    input  logic [7:0]    digit_byte,
    input  logic [9:0]    acc_in,
    input  logic [CW-1:0] cnt_in,
    output logic          is_digit,
    output logic [9:0]    acc_out,
    output logic [CW-1:0] cnt_out,
    output logic          overflow
);

    logic [3:0]  digit_val;
    logic [13:0] wide_sum;
    logic [CW:0] wide_cnt;

    // The product is formed wider than the stored accumulator so that a
    // value such as 255*10+9 is still seen whole by the overflow compare.
    assign is_digit  = (digit_byte >= CH_0) && (digit_byte <= CH_9);
    assign digit_val = digit_byte[3:0];
    assign wide_sum  = ({4'b0000, acc_in} * 14'd10) + {10'b0, digit_val};
    assign wide_cnt  = {1'b0, cnt_in} + {{CW{1'b0}}, 1'b1};
    assign acc_out   = wide_sum[9:0];
    assign cnt_out   = wide_cnt[CW-1:0];
    assign overflow  = is_digit &&
                       ((wide_sum > 14'd255) || (wide_cnt > (CW+1)'(MAX_DIGITS)));

endmodule

// File: rtl/alu_cmd_parser.sv
// alu_cmd_parser
//   Parses ASCII command lines of the form <num1><op><num2><TERM_CHAR>
//   arriving one byte per rx_valid strobe and hands the decoded operands and
//   opcode to the ALU. Spaces are ignored anywhere in a line. A well-formed
//   line produces a one-cycle cmd_valid pulse with updated num1/num2/oper;
//   a malformed line is discarded up to its terminator and produces a
//   one-cycle cmd_err pulse with the outputs left as they were.
//   Ports:
//     clk        in   clock, all state on rising edge
//     rst        in   asynchronous active-high reset
//     rx_data    in   received byte, qualified by rx_valid
//     rx_valid   in   one-cycle strobe per received byte
//     num1       out  first operand (registered)
//     num2       out  second operand (registered)
//     oper       out  ALU opcode (registered)
//     cmd_valid  out  pulse: new num1/num2/oper
//     cmd_err    out  pulse: malformed line discarded
//   Build option:
//     ALU_DIV0_CHECK_EN  when defined, '/' or '%' with a zero second operand
//                        is reported with cmd_err instead of being committed.
module alu_cmd_parser
    import alu_pkg::*;
#(
    parameter logic [7:0] TERM_CHAR  = 8'h0D,
    parameter int         MAX_DIGITS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] num1,
    output logic [7:0] num2,
    output logic [3:0] oper,
    output logic       cmd_valid,
    output logic       cmd_err
);

    localparam int CW = $clog2(MAX_DIGITS + 1) + 1;

    state_t        state, state_nxt;
    logic [9:0]    acc, acc_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [7:0]    shadow_num1, shadow_num1_nxt;
    logic [3:0]    shadow_op, shadow_op_nxt;
    logic [7:0]    num1_nxt, num2_nxt;
    logic [3:0]    oper_nxt;
    logic          valid_nxt, err_nxt;

    logic [9:0]    acc_feed;
    logic [CW-1:0] cnt_feed;
    logic          is_digit, overflow;
    logic [9:0]    dig_acc;
    logic [CW-1:0] dig_cnt;
    logic          is_op;
    logic [3:0]    op_code;
    logic          div0;

    // A digit seen in IDLE starts a fresh operand, so the accumulator is fed
    // zero there regardless of what was left behind by an earlier line.
    assign acc_feed = (state == ST_IDLE) ? '0 : acc;
    assign cnt_feed = (state == ST_IDLE) ? '0 : cnt;

    dec_acc #(
        .MAX_DIGITS (MAX_DIGITS),
        .CW         (CW)
    ) u_dec_acc (
        .digit_byte (rx_data),
        .acc_in     (acc_feed),
        .cnt_in     (cnt_feed),
        .is_digit   (is_digit),
        .acc_out    (dig_acc),
        .cnt_out    (dig_cnt),
        .overflow   (overflow)
    );

    assign {is_op, op_code} = decode_op(rx_data);

    // In NUM2 the accumulator holds the second operand, so a zero there with
    // a division opcode latched means the ALU would divide by zero.
`ifdef ALU_DIV0_CHECK_EN
    assign div0 = ((shadow_op == OP_DIV) || (shadow_op == OP_MOD)) && (acc == '0);
`else
    assign div0 = 1'b0;
`endif

    // Next-state and datapath logic. Only strobed, non-space bytes move the
    // parser; everything holds otherwise and the two pulses default low so
    // they last exactly one cycle. The first operand and opcode wait in
    // shadow registers until the terminator proves the whole line good.
    always_comb begin
        state_nxt       = state;
        acc_nxt         = acc;
        cnt_nxt         = cnt;
        shadow_num1_nxt = shadow_num1;
        shadow_op_nxt   = shadow_op;
        num1_nxt        = num1;
        num2_nxt        = num2;
        oper_nxt        = oper;
        valid_nxt       = 1'b0;
        err_nxt         = 1'b0;

        if (rx_valid && (rx_data != CH_SPACE)) begin
            case (state)
                ST_IDLE: begin
                    if (is_digit && !overflow) begin
                        acc_nxt   = dig_acc;
                        cnt_nxt   = dig_cnt;
                        state_nxt = ST_NUM1;
                    end else if (rx_data != TERM_CHAR) begin
                        state_nxt = ST_DRAIN;
                    end
                end

                ST_NUM1: begin
                    if (is_digit) begin
                        if (overflow) begin
                            state_nxt = ST_DRAIN;
                        end else begin
                            acc_nxt = dig_acc;
                            cnt_nxt = dig_cnt;
                        end
                    end else if (is_op && (cnt != '0)) begin
                        shadow_num1_nxt = acc[7:0];
                        shadow_op_nxt   = op_code;
                        acc_nxt         = '0;
                        cnt_nxt         = '0;
                        state_nxt       = ST_NUM2;
                    end else if (rx_data == TERM_CHAR) begin
                        err_nxt   = 1'b1;
                        acc_nxt   = '0;
                        cnt_nxt   = '0;
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_DRAIN;
                    end
                end

                ST_NUM2: begin
                    if (is_digit) begin
                        if (overflow) begin
                            state_nxt = ST_DRAIN;
                        end else begin
                            acc_nxt = dig_acc;
                            cnt_nxt = dig_cnt;
                        end
                    end else if (rx_data == TERM_CHAR) begin
                        if ((cnt != '0) && !div0) begin
                            num1_nxt  = shadow_num1;
                            num2_nxt  = acc[7:0];
                            oper_nxt  = shadow_op;
                            valid_nxt = 1'b1;
                        end else begin
                            err_nxt = 1'b1;
                        end
                        acc_nxt   = '0;
                        cnt_nxt   = '0;
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_DRAIN;
                    end
                end

                ST_DRAIN: begin
                    if (rx_data == TERM_CHAR) begin
                        err_nxt   = 1'b1;
                        acc_nxt   = '0;
                        cnt_nxt   = '0;
                        state_nxt = ST_IDLE;
                    end
                end

                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers. Reset drops any partial line silently and
    // returns every visible output to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            acc         <= '0;
            cnt         <= '0;
            shadow_num1 <= 8'h00;
            shadow_op   <= OP_ADD;
            num1        <= 8'h00;
            num2        <= 8'h00;
            oper        <= 4'b0000;
            cmd_valid   <= 1'b0;
            cmd_err     <= 1'b0;
        end else begin
            state       <= state_nxt;
            acc         <= acc_nxt;
            cnt         <= cnt_nxt;
            shadow_num1 <= shadow_num1_nxt;
            shadow_op   <= shadow_op_nxt;
            num1        <= num1_nxt;
            num2        <= num2_nxt;
            oper        <= oper_nxt;
            cmd_valid   <= valid_nxt;
            cmd_err     <= err_nxt;
        end
    end

endmodule

// File: tb/tb_alu_cmd_parser.sv
// tb_alu_cmd_parser
//   Self-checking bench for alu_cmd_parser. A reference model parses each
//   complete line as a whole (pattern digits-operator-digits, value and
//   length limits) and predicts the pulse and outputs for every cycle.
//   Fixed lines with known results come from a vector table; random lines,
//   idle gaps and a mid-line reset are mixed in.
//   Build option: ALU_DIV0_CHECK_EN changes the expected result of a
//   division or remainder by zero.
`timescale 1ns/1ps
module tb_alu_cmd_parser;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] num1;
    logic [7:0] num2;
    logic [3:0] oper;
    logic       cmd_valid;
    logic       cmd_err;

    int checks = 0;
    int errors = 0;

    // Reference model state: the bytes of the line seen so far (spaces
    // dropped) and the outputs expected right now.
    logic [7:0] frame_q[$];
    logic [7:0] exp_num1;
    logic [7:0] exp_num2;
    logic [3:0] exp_oper;
    logic       exp_valid;
    logic       exp_err;

    typedef struct {
        string      frame;
        logic       ev;
        logic       ee;
        logic [7:0] n1;
        logic [7:0] n2;
        logic [3:0] op;
    } vec_t;

    vec_t tbl[$];

    alu_cmd_parser dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .num1      (num1),
        .num2      (num2),
        .oper      (oper),
        .cmd_valid (cmd_valid),
        .cmd_err   (cmd_err)
    );

    // 100 MHz free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkField(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    task automatic checkOutput(input string name);
        checkField({name, ".cmd_valid"}, 32'(cmd_valid), 32'(exp_valid));
        checkField({name, ".cmd_err"},   32'(cmd_err),   32'(exp_err));
        checkField({name, ".num1"},      32'(num1),      32'(exp_num1));
        checkField({name, ".num2"},      32'(num2),      32'(exp_num2));
        checkField({name, ".oper"},      32'(oper),      32'(exp_oper));
    endtask

    function automatic bit isDigit(input logic [7:0] b);
        return (b >= 8'h30) && (b <= 8'h39);
    endfunction

    // Judge a complete line against the grammar: 1..3 digits with value at
    // most 255, one operator, 1..3 digits with value at most 255, nothing else.
    task automatic evaluateFrame(output bit ok, output int a, output int b, output logic [3:0] op);
        int i;
        int nd1;
        int nd2;
        ok = 1'b0; a = 0; b = 0; op = 4'b0000; i = 0; nd1 = 0; nd2 = 0;
        while (i < frame_q.size() && isDigit(frame_q[i])) begin
            if (nd1 < 8) a = a * 10 + int'(frame_q[i] - 8'h30);
            nd1++; i++;
        end
        if (nd1 < 1 || nd1 > 3 || a > 255 || i >= frame_q.size()) return;
        case (frame_q[i])
            8'h2B: op = 4'b0000;
            8'h2D: op = 4'b0001;
            8'h2A: op = 4'b0010;
            8'h2F: op = 4'b0100;
            8'h25: op = 4'b1000;
            default: return;
        endcase
        i++;
        while (i < frame_q.size() && isDigit(frame_q[i])) begin
            if (nd2 < 8) b = b * 10 + int'(frame_q[i] - 8'h30);
            nd2++; i++;
        end
        if (nd2 < 1 || nd2 > 3 || b > 255 || i != frame_q.size()) return;
        ok = 1'b1;
    endtask

    // Advance the model by one accepted byte.
    task automatic modelByte(input logic [7:0] b);
        bit         ok;
        int         a;
        int         bv;
        logic [3:0] op;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        if (b == 8'h20) return;
        if (b != 8'h0D) begin
            frame_q.push_back(b);
            return;
        end
        if (frame_q.size() == 0) return;
        evaluateFrame(ok, a, bv, op);
`ifdef ALU_DIV0_CHECK_EN
        if (ok && (op == 4'b0100 || op == 4'b1000) && bv == 0) ok = 1'b0;
`endif
        if (ok) begin
            exp_valid = 1'b1;
            exp_num1  = 8'(a);
            exp_num2  = 8'(bv);
            exp_oper  = op;
        end else begin
            exp_err = 1'b1;
        end
        frame_q.delete();
    endtask

    // One clock cycle: present a byte (strobed or not), then check every
    // output just after the edge against the model.
    task automatic applyStimulus(input logic [7:0] b, input logic v);
        @(negedge clk);
        rx_data  = b;
        rx_valid = v;
        @(posedge clk);
        #1;
        if (v) modelByte(b);
        else begin
            exp_valid = 1'b0;
            exp_err   = 1'b0;
        end
        checkOutput("cycle");
    endtask

    task automatic sendFrame(input string s);
        for (int i = 0; i < s.len(); i++) applyStimulus(s[i], 1'b1);
        applyStimulus(8'h0D, 1'b1);
    endtask

    task automatic modelReset();
        frame_q.delete();
        exp_num1  = 8'h00;
        exp_num2  = 8'h00;
        exp_oper  = 4'b0000;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
    endtask

    function automatic string opStr(input int k);
        case (k)
            0: return "+";
            1: return "-";
            2: return "*";
            3: return "/";
            default: return "%";
        endcase
    endfunction

    initial begin
        string s;
        int    a;
        int    b;
        int    k;

        rst      = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset");
        @(negedge clk);
        rst = 1'b0;

        tbl.push_back('{"12+34",     1'b1, 1'b0, 8'd12,  8'd34,  4'b0000});
        tbl.push_back('{"255 * 2",   1'b1, 1'b0, 8'd255, 8'd2,   4'b0010});
        tbl.push_back('{"256+1",     1'b0, 1'b1, 8'd255, 8'd2,   4'b0010});
`ifdef ALU_DIV0_CHECK_EN
        tbl.push_back('{"7/0",       1'b0, 1'b1, 8'd255, 8'd2,   4'b0010});
        tbl.push_back('{"x9+1",      1'b0, 1'b1, 8'd255, 8'd2,   4'b0010});
`else
        tbl.push_back('{"7/0",       1'b1, 1'b0, 8'd7,   8'd0,   4'b0100});
        tbl.push_back('{"x9+1",      1'b0, 1'b1, 8'd7,   8'd0,   4'b0100});
`endif
        tbl.push_back('{"9%4",       1'b1, 1'b0, 8'd9,   8'd4,   4'b1000});
        tbl.push_back('{"",          1'b0, 1'b0, 8'd9,   8'd4,   4'b1000});
        tbl.push_back('{"12",        1'b0, 1'b1, 8'd9,   8'd4,   4'b1000});
        tbl.push_back('{"0012+1",    1'b0, 1'b1, 8'd9,   8'd4,   4'b1000});
        tbl.push_back('{"100-99",    1'b1, 1'b0, 8'd100, 8'd99,  4'b0001});
        tbl.push_back('{"5+",        1'b0, 1'b1, 8'd100, 8'd99,  4'b0001});
        tbl.push_back('{"5+3+",      1'b0, 1'b1, 8'd100, 8'd99,  4'b0001});
        tbl.push_back('{" 0 / 255 ", 1'b1, 1'b0, 8'd0,   8'd255, 4'b0100});
        tbl.push_back('{"+5",        1'b0, 1'b1, 8'd0,   8'd255, 4'b0100});
        tbl.push_back('{"007*1000",  1'b0, 1'b1, 8'd0,   8'd255, 4'b0100});

        // Table lines go back to back; the result is checked in the cycle
        // right after each terminator.
        for (int i = 0; i < tbl.size(); i++) begin
            sendFrame(tbl[i].frame);
            checkField($sformatf("tbl%0d.cmd_valid", i), 32'(cmd_valid), 32'(tbl[i].ev));
            checkField($sformatf("tbl%0d.cmd_err", i),   32'(cmd_err),   32'(tbl[i].ee));
            checkField($sformatf("tbl%0d.num1", i),      32'(num1),      32'(tbl[i].n1));
            checkField($sformatf("tbl%0d.num2", i),      32'(num2),      32'(tbl[i].n2));
            checkField($sformatf("tbl%0d.oper", i),      32'(oper),      32'(tbl[i].op));
        end

        // Unstrobed bytes, including the terminator, must be ignored.
        applyStimulus(8'h0D, 1'b0);
        applyStimulus(8'h31, 1'b0);
        applyStimulus(8'h0D, 1'b0);

        // Reset in the middle of a line: outputs clear at once, no pulse
        // while reset is held, and the next line parses from scratch.
        sendFrame("8*8");
        s = "12+";
        for (int i = 0; i < s.len(); i++) applyStimulus(s[i], 1'b1);
        #2;
        rst      = 1'b1;
        rx_valid = 1'b0;
        modelReset();
        #1;
        checkOutput("async_reset");
        repeat (3) begin
            @(posedge clk);
            #1;
            checkOutput("in_reset");
        end
        @(negedge clk);
        rst = 1'b0;
        sendFrame("5-3");
        checkField("rst_seq.cmd_valid", 32'(cmd_valid), 32'd1);
        checkField("rst_seq.num1",      32'(num1),      32'd5);
        checkField("rst_seq.num2",      32'(num2),      32'd3);
        checkField("rst_seq.oper",      32'(oper),      32'd1);

        // Random lines, mostly well-formed, with occasional leading zeros,
        // out-of-range values, missing operands, junk and idle gaps.
        for (int f = 0; f < 120; f++) begin
            a = $urandom_range(0, 280);
            b = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(0, 280);
            k = $urandom_range(0, 4);
            s = "";
            if ($urandom_range(0, 7) == 0) s = {s, "0"};
            if ($urandom_range(0, 15) != 0) s = {s, $sformatf("%0d", a)};
            if ($urandom_range(0, 3) == 0) s = {s, " "};
            s = {s, opStr(k)};
            if ($urandom_range(0, 3) == 0) s = {s, " "};
            if ($urandom_range(0, 9) != 0) s = {s, $sformatf("%0d", b)};
            if ($urandom_range(0, 11) == 0) s = {s, "x"};
            for (int i = 0; i < s.len(); i++) begin
                if ($urandom_range(0, 4) == 0) applyStimulus(8'($urandom), 1'b0);
                applyStimulus(s[i], 1'b1);
            end
            applyStimulus(8'h0D, 1'b1);
        end

        repeat (2) applyStimulus(8'h00, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_cmd_parser.md
ALU_CMD_PARSER -- requirements
Module: alu_cmd_parser

Interface
REQ-001 Parameter: TERM_CHAR, 8'h0D, frame terminator byte.
REQ-002 Parameter: MAX_DIGITS, 3, maximum decimal digits per operand.
REQ-003 Port: clk  input  1  single clock; all state on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: rx_data  input  8  received UART byte, valid only with rx_valid.
REQ-006 Port: rx_valid  input  1  one-cycle strobe per received byte.
REQ-007 Port: num1  output  8  first operand to ALU, registered.
REQ-008 Port: num2  output  8  second operand to ALU, registered.
REQ-009 Port: oper  output  4  one-hot-style ALU opcode, registered.
REQ-010 Port: cmd_valid  output  1  one-cycle pulse, new num1/num2/oper valid.
REQ-011 Port: cmd_err  output  1  one-cycle pulse, malformed frame discarded.

Function
REQ-012 Frame SHALL be: digits(num1), operator, digits(num2), TERM_CHAR; byte 0x20 (space) ignored in every state.
REQ-013 Operator map SHALL be: '+'->4'b0000, '-'->4'b0001, '*'->4'b0010, '/'->4'b0100 (quotient), '%'->4'b1000 (remainder).
REQ-014 FSM states SHALL be IDLE, NUM1, NUM2, DRAIN; bytes processed only on cycles with rx_valid=1.
REQ-015 IDLE: digit -> load acc, NUM1; TERM_CHAR -> stay IDLE, no pulse (empty line); any other byte -> DRAIN.
REQ-016 NUM1: digit -> acc=acc*10+d; operator with >=1 digit -> latch num1 and opcode into shadow regs, clear acc, NUM2; TERM_CHAR or other byte -> DRAIN (TERM_CHAR: directly cmd_err, IDLE).
REQ-017 NUM2: digit -> accumulate; TERM_CHAR with >=1 digit -> commit, IDLE; TERM_CHAR with 0 digits -> cmd_err, IDLE; other byte -> DRAIN.
REQ-018 DRAIN: discard bytes until TERM_CHAR, then pulse cmd_err and return to IDLE.
REQ-019 Accumulator SHALL be 10 bits; value >255 or digit count >MAX_DIGITS -> DRAIN; leading zeros count toward digit limit.
REQ-020 Commit: num1/num2/oper updated and cmd_valid=1 in the cycle after the TERM_CHAR edge (latency 1 clk); outputs hold until next commit.
REQ-021 cmd_valid and cmd_err SHALL never assert in the same cycle; neither asserts on cycles without a preceding accepted byte.
REQ-022 Back-to-back rx_valid on consecutive cycles SHALL be accepted with no byte loss.

Reset
REQ-023 rst SHALL asynchronously force: state IDLE, acc 0, digit count 0, num1 8'h00, num2 8'h00, oper 4'b0000, cmd_valid 0, cmd_err 0.
REQ-024 rst mid-frame SHALL discard the partial frame with no pulse; first byte after release starts a new frame.

Configuration
REQ-025 Macro ALU_DIV0_CHECK_EN: when defined, '/' or '%' with num2==0 SHALL pulse cmd_err instead of cmd_valid and leave outputs unchanged.
REQ-026 Without ALU_DIV0_CHECK_EN, such frames SHALL commit normally with cmd_valid.

Structure
REQ-027 Shared package alu_pkg SHALL hold opcode constants (OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD), ASCII constants, and FSM state encoding, also used by ALU and the result transmitter.
REQ-028 One sub-module dec_acc (digit validate, acc*10+d, overflow and digit-count flags) SHALL be instantiated once.

Verification
REQ-029 Bytes "12+34\r" -> one cycle after '\r': cmd_valid=1, num1=12, num2=34, oper=4'b0000.
REQ-030 "255 * 2\r" -> cmd_valid, num1=255, num2=2, oper=4'b0010; "256+1\r" -> cmd_err only, outputs unchanged.
REQ-031 "7/0\r": with ALU_DIV0_CHECK_EN -> cmd_err; without -> cmd_valid, num2=0, oper=4'b0100.
REQ-032 "x9+1\r" then "9%4\r" back-to-back -> cmd_err, then cmd_valid with num1=9, num2=4, oper=4'b1000.
REQ-033 rst asserted after "12+" then "5-3\r" -> no pulse during reset, then cmd_valid num1=5, num2=3, oper=4'b0001.
